if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
- Instruction-fetch stage for the multi-cycle LoongArch core; sits directly upstream of decode.
- Drives the synchronous inst SRAM (1-cycle read latency) and tags each returned word with its PC.
- Holds fetched words in a small FIFO and hands them to decode over a valid/ready handshake.
- Applies branch/jump redirects: flushes the FIFO, discards the in-flight read, restarts at the target.

Parameters:
RESET_PC, 32'h1c00_0000, first fetch address after reset
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
inst_sram_en  output  1  read request this cycle
inst_sram_we  output  1  tied 0
inst_sram_addr  output  32  word address of request, bits [1:0]=0
inst_sram_wdata  output  32  tied 0
inst_sram_rdata  input  32  read data, valid the cycle after an accepted request
br_taken  input  1  redirect pulse from decode/execute
br_target  input  32  redirect address
id_ready  input  1  decode accepts head entry this cycle
if_valid  output  1  head entry valid
if_pc  output  32  PC of head entry, 0 when empty
if_inst  output  32  instruction of head entry, 0 when empty

Behaviour:
- State: fpc (next fetch PC), FIFO of DEPTH {pc,inst} entries with count, inflight bit, inflight_pc.
- Reset values: fpc=RESET_PC, count=0, inflight=0, pointers=0. While reset is high: inst_sram_en=0, if_valid=0, if_pc=0, if_inst=0, inst_sram_addr=RESET_PC.
- pop = if_valid & id_ready.
- Issue rule (no redirect): inst_sram_en = (count + inflight - pop) < DEPTH. Address = fpc. On issue: fpc <= fpc+4 (32-bit wrap, 32'hffff_fffc+4 -> 0), inflight <= 1, inflight_pc <= fpc. If no issue: inflight <= 0.
- Response: if inflight=1 at a rising edge, {inflight_pc, inst_sram_rdata} is written into the FIFO on that edge. No bypass: a word returned in cycle N is first visible on if_valid in cycle N+1.
- Latency: request in cycle N -> data captured at end of N+1 -> if_valid in N+2.
- Steady state with id_ready=1: one instruction per cycle.
- if_valid = (count!=0) & ~br_taken. if_pc/if_inst show the head entry, or 0 when count=0.
- Simultaneous push and pop: count unchanged. The push never overflows, guaranteed by the issue rule. Assert if a push occurs with count=DEPTH and no pop.
- Redirect cycle (br_taken=1):
  - if_valid forced 0, so no pop.
  - inst_sram_en=1 with inst_sram_addr={br_target[31:2],2'b00}.
  - At the edge: FIFO cleared (count=0, pointers=0); any response returning this cycle is dropped.
  - inflight<=1, inflight_pc<={br_target[31:2],2'b00}, fpc<={br_target[31:2],2'b00}+4.
- Back-to-back redirects: each cycle's target wins; earlier targets are discarded.
- Redirect wins over every other event in the same cycle.
- id_ready while if_valid=0 has no effect.
- Reset asserted mid-operation clears everything immediately, including inflight; the first request is RESET_PC in the first cycle after reset deasserts.

Test Plan:
- Reset release, id_ready=1, SRAM returns addr as data -> en=1 from cycle 0; if_valid rises in cycle 2 with if_pc=1c000000, if_inst=1c000000; then 1c000004, 1c000008 on consecutive cycles.
- id_ready=0 from reset -> exactly 2 requests issued (1c000000, 1c000004), count=2, en=0. Raise id_ready -> 1c000000 popped first and fetch resumes at 1c000008 with no gaps.
- br_taken=1, br_target=1c000103 while FIFO full and a read in flight -> if_valid=0 that cycle, addr=1c000100; next delivered PC is 1c000100, then 1c000104; no stale PC appears.
- br_taken on two consecutive cycles, targets 1c000200 then 1c000300 -> first delivered PC is 1c000300.
- Set fpc to ffff_fffc via redirect -> delivers fffffffc, then 00000000.
- Assert reset for 1 cycle mid-stream with FIFO full -> outputs 0 immediately; fetch restarts at 1c000000.

Source files
------------

// File: rtl/if_fetch_buffer_if.sv
// Fetch-stage bundle: inst SRAM request/response, redirect input and the
// valid/ready link to decode. master = fetch unit, slave = its environment.
interface if_fetch_buffer_if;
    logic        inst_sram_en;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    // Decode handshake: an entry moves to decode on a rising edge where
    // if_valid and id_ready are both high; if_pc/if_inst hold until then.
    modport master (
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        output if_valid, if_pc, if_inst,
        input  inst_sram_rdata, br_taken, br_target, id_ready
    );

    modport slave (
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
        input  if_valid, if_pc, if_inst,
        output inst_sram_rdata, br_taken, br_target, id_ready
    );
endinterface

// File: rtl/if_fetch_buffer.sv
// Instruction fetch stage: issues inst SRAM reads, tags returned words with
// their PC, buffers them in a small FIFO and applies branch redirects.
module if_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    if_fetch_buffer_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [31:0]      r_fpc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_inflight;
    logic [31:0]      r_inflight_pc;
    logic [31:0]      r_mem_pc   [DEPTH];
    logic [31:0]      r_mem_inst [DEPTH];

    logic [31:0]      w_br_pc;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic [CNT_W:0]   w_occ;

    assign w_br_pc = {bus.br_target[31:2], 2'b00};
    assign w_empty = (r_count == '0);
    assign w_pop   = bus.if_valid & bus.id_ready;
    // A response landing in a redirect cycle belongs to the old stream.
    assign w_push  = r_inflight & ~bus.br_taken;

    // Entries held after this edge plus the word still in flight; issuing only
    // while this stays below DEPTH means a response always finds a free slot.
    assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight}
                   - {{CNT_W{1'b0}}, w_pop};
    assign w_issue = ~reset & (bus.br_taken | (w_occ < DEPTH_OCC));

    assign bus.inst_sram_en    = w_issue;
    assign bus.inst_sram_we    = 1'b0;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.inst_sram_addr  = reset        ? RESET_PC :
                                 bus.br_taken ? w_br_pc  : r_fpc;

    assign bus.if_valid = ~w_empty & ~bus.br_taken;
    assign bus.if_pc    = w_empty ? 32'h0 : r_mem_pc[r_rptr];
    assign bus.if_inst  = w_empty ? 32'h0 : r_mem_inst[r_rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpc         <= RESET_PC;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else if (bus.br_taken) begin
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_br_pc;
            r_fpc         <= w_br_pc + 32'd4;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_issue) begin
                r_fpc         <= r_fpc + 32'd4;
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fpc;
            end else begin
                r_inflight    <= 1'b0;
            end
        end
    end

    // Payload storage needs no reset: count gates everything visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]   <= r_inflight_pc;
            r_mem_inst[r_wptr] <= bus.inst_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push && !w_pop)
            assert (r_count != DEPTH_CNT);
    end
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed bench for if_fetch_buffer: expected PCs are queued by the stimulus
// and a negedge monitor checks every word handed to decode.
module tb_if_fetch_buffer;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   req_cnt;
    int   base;
    logic [31:0] exp_q[$];

    if_fetch_buffer_if bus ();

    if_fetch_buffer #(.RESET_PC(32'h1c00_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 1-cycle latency, returns the requested address as data
    initial req_cnt = 0;
    always @(posedge clk) begin
        if (bus.inst_sram_en) begin
            bus.inst_sram_rdata <= bus.inst_sram_addr;
            req_cnt <= req_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pc);
            pc = pc + 32'd4;
        end
    endtask

    // Called just after a rising edge; waits for the monitor to consume all.
    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 60) begin
            @(posedge clk);
            #1;
            i++;
        end
        check({name, " drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset && bus.if_valid && bus.id_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", bus.if_pc, 32'hdead_beef);
            end else begin
                e = exp_q.pop_front();
                check("deliver_pc", bus.if_pc, e);
                check("deliver_inst", bus.if_inst, e);
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'h0;
        bus.id_ready  = 1'b0;
        bus.inst_sram_rdata = 32'h0;

        // Reset values and first-fetch latency
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en", 32'(bus.inst_sram_en), 32'd0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_pc", bus.if_pc, 32'h0);
        check("rst_inst", bus.if_inst, 32'h0);
        check("rst_addr", bus.inst_sram_addr, 32'h1c00_0000);
        push_seq(32'h1c00_0000, 4);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.id_ready = 1'b1;
        @(negedge clk);
        check("c0_en", 32'(bus.inst_sram_en), 32'd1);
        check("c0_addr", bus.inst_sram_addr, 32'h1c00_0000);
        check("c0_valid", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        check("c1_valid", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        check("c2_valid", 32'(bus.if_valid), 32'd1);
        @(posedge clk); #1;
        wait_drain("stream");
        bus.id_ready = 1'b0;

        // Back-pressure from reset: exactly two requests, then stall
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst2_valid", 32'(bus.if_valid), 32'd0);
        @(posedge clk); #1;
        base  = req_cnt;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bp_reqs", 32'(req_cnt - base), 32'd2);
        check("bp_en", 32'(bus.inst_sram_en), 32'd0);
        check("bp_valid", 32'(bus.if_valid), 32'd1);
        check("bp_head", bus.if_pc, 32'h1c00_0000);
        push_seq(32'h1c00_0000, 6);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_nogap", 32'(bus.if_valid), 32'd1);
        end
        @(posedge clk); #1;
        wait_drain("bp");
        bus.id_ready = 1'b0;

        // Redirect while FIFO full; unaligned target
        repeat (4) @(posedge clk);
        #1;
        check("full_valid", 32'(bus.if_valid), 32'd1);
        check("full_en", 32'(bus.inst_sram_en), 32'd0);
        push_seq(32'h1c00_0100, 3);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0103;
        bus.id_ready  = 1'b1;
        @(negedge clk);
        check("br_valid", 32'(bus.if_valid), 32'd0);
        check("br_en", 32'(bus.inst_sram_en), 32'd1);
        check("br_addr", bus.inst_sram_addr, 32'h1c00_0100);
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        wait_drain("br");
        bus.id_ready = 1'b0;

        // Back-to-back redirects: the later target wins
        push_seq(32'h1c00_0300, 3);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c00_0200;
        bus.id_ready  = 1'b1;
        @(negedge clk);
        check("bb1_valid", 32'(bus.if_valid), 32'd0);
        check("bb1_addr", bus.inst_sram_addr, 32'h1c00_0200);
        @(posedge clk); #1;
        bus.br_target = 32'h1c00_0300;
        @(negedge clk);
        check("bb2_valid", 32'(bus.if_valid), 32'd0);
        check("bb2_addr", bus.inst_sram_addr, 32'h1c00_0300);
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        wait_drain("bb");
        bus.id_ready = 1'b0;

        // PC wraparound at the top of the address space
        exp_q.push_back(32'hffff_fffc);
        push_seq(32'h0000_0000, 2);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'hffff_fffc;
        bus.id_ready  = 1'b1;
        @(negedge clk);
        check("wrap_addr", bus.inst_sram_addr, 32'hffff_fffc);
        @(posedge clk); #1;
        bus.br_taken = 1'b0;
        wait_drain("wrap");
        bus.id_ready = 1'b0;

        // Reset mid-stream with FIFO full
        repeat (4) @(posedge clk);
        #1;
        check("mid_full_valid", 32'(bus.if_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.if_valid), 32'd0);
        check("mid_rst_pc", bus.if_pc, 32'h0);
        check("mid_rst_inst", bus.if_inst, 32'h0);
        check("mid_rst_en", 32'(bus.inst_sram_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.id_ready = 1'b1;
        push_seq(32'h1c00_0000, 3);
        @(negedge clk);
        check("restart_en", 32'(bus.inst_sram_en), 32'd1);
        check("restart_addr", bus.inst_sram_addr, 32'h1c00_0000);
        @(posedge clk); #1;
        wait_drain("restart");
        bus.id_ready = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
